// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: byte FIFO fed by CPU stores, 8N1 serialiser (LSB first),
// and a registered status word for software polling.
module mmio_uart_tx #(
  parameter int DW         = 16,
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115_200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic          clk50m,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  input  logic          clr_ovf,
  output logic [DW-1:0] status,
  output logic          tx
);

  localparam int DIV    = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int CNT_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int FCNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0]  BAUD_LAST = CNT_W'(DIV - 1);
  localparam logic [FCNT_W-1:0] FULL_CNT  = FCNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    baud_q, baud_d;
  logic [2:0]          bit_idx_q, bit_idx_d;
  logic [7:0]          shift_q, shift_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [FCNT_W-1:0]   count_q, count_d;
  logic                ovf_q, ovf_d;
  logic                tx_q, tx_d;
  logic [DW-1:0]       status_q, status_d;
  logic [7:0]          mem_q [FIFO_DEPTH];

  logic full, empty, push, pop, baud_done;

  always_comb begin
    full      = (count_q == FULL_CNT);
    empty     = (count_q == '0);
    push      = wr_en && !full;
    pop       = (state_q == S_IDLE) && !empty;
    baud_done = (baud_q == BAUD_LAST);

    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + FCNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - FCNT_W'(1);
    end

    // A dropped byte must win over a simultaneous clear so no overflow goes unseen.
    ovf_d = ovf_q;
    if (wr_en && full) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end
  end

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;

    unique case (state_q)
      S_IDLE: begin
        baud_d = '0;
        if (pop) begin
          shift_d = mem_q[rd_ptr_q];
          state_d = S_START;
        end
      end
      S_START: begin
        if (baud_done) begin
          baud_d    = '0;
          bit_idx_d = 3'd0;
          state_d   = S_DATA;
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (baud_done) begin
          baud_d    = '0;
          shift_d   = {1'b0, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
          end
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (baud_done) begin
          baud_d  = '0;
          state_d = S_IDLE;
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        baud_d  = '0;
      end
    endcase
  end

  // Line and status are registered from the current state, so both trail the FSM by one cycle.
  always_comb begin
    unique case (state_q)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_q[0];
      default: tx_d = 1'b1;
    endcase

    status_d      = '0;
    status_d[0]   = (state_q != S_IDLE);
    status_d[1]   = full;
    status_d[2]   = empty;
    status_d[3]   = ovf_q;
    status_d[7:4] = 4'(count_q);
  end

  always_ff @(posedge clk50m) begin
    if (rst) begin
      state_q   <= S_IDLE;
      baud_q    <= '0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      tx_q      <= 1'b1;
      status_q  <= DW'(4);
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      tx_q      <= tx_d;
      status_q  <= status_d;
    end
  end

  always_ff @(posedge clk50m) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign tx     = tx_q;
  assign status = status_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx at DIV=10: a queue/timeline model of the line and status word
// is compared every cycle, with literal expectations at key points of each scenario.
module tb_mmio_uart_tx;

  localparam int DIV   = 10;
  localparam int DEPTH = 8;

  logic        clk50m;
  logic        rst;
  logic        wr_en;
  logic [7:0]  wr_data;
  logic        clr_ovf;
  logic [15:0] status;
  logic        tx;

  int checks = 0;
  int errors = 0;

  mmio_uart_tx #(
    .DW(16),
    .CLK_HZ(50_000_000),
    .BAUD(5_000_000),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk50m (clk50m),
    .rst    (rst),
    .wr_en  (wr_en),
    .wr_data(wr_data),
    .clr_ovf(clr_ovf),
    .status (status),
    .tx     (tx)
  );

  initial begin
    clk50m = 1'b0;
    forever #10 clk50m = ~clk50m;
  end

  initial begin
    #(20 * 200_000);
    $display("[TB] FAIL watchdog: simulation did not complete within 200000 cycles");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, actual, expected);
    end
  endtask

  // One-cycle strobe: inputs set after a falling edge, sampled at the next rising edge.
  task automatic applyStimulus(input logic wr, input logic [7:0] data, input logic clr);
    @(negedge clk50m);
    wr_en   = wr;
    wr_data = data;
    clr_ovf = clr;
    @(negedge clk50m);
    wr_en   = 1'b0;
    clr_ovf = 1'b0;
  endtask

  // Behavioural model: a byte queue plus a frame timeline p = 0..10*DIV-1.
  byte unsigned mq[$];
  bit           m_sending;
  int           m_p;
  logic [7:0]   m_cur;
  bit           m_ovf;
  bit           model_valid = 1'b0;
  logic         exp_tx;
  logic [15:0]  exp_status;

  function automatic logic frame_bit(input int p, input logic [7:0] b);
    int idx;
    idx = p / DIV;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
    return 1'b1;
  endfunction

  always @(posedge clk50m) begin
    bit m_full;
    if (rst) begin
      mq.delete();
      m_sending  = 1'b0;
      m_p        = 0;
      m_ovf      = 1'b0;
      exp_tx     = 1'b1;
      exp_status = 16'h0004;
      model_valid = 1'b1;
    end else begin
      m_full     = (mq.size() == DEPTH);
      exp_tx     = m_sending ? frame_bit(m_p, m_cur) : 1'b1;
      exp_status = {8'h00, 4'(mq.size()), m_ovf, (mq.size() == 0), m_full, m_sending};
      if (m_sending) begin
        m_p++;
        if (m_p == 10 * DIV) m_sending = 1'b0;
      end else if (mq.size() > 0) begin
        m_cur     = mq.pop_front();
        m_sending = 1'b1;
        m_p       = 0;
      end
      if (wr_en && !m_full) mq.push_back(wr_data);
      if (wr_en && m_full) m_ovf = 1'b1;
      else if (clr_ovf) m_ovf = 1'b0;
    end
  end

  always @(negedge clk50m) begin
    if (model_valid) begin
      checkOutput("model_tx", {15'b0, tx}, {15'b0, exp_tx});
      checkOutput("model_status", status, exp_status);
    end
  end

  initial begin
    logic [9:0] frame;
    int lows;

    rst = 1'b1;
    wr_en = 1'b0;
    wr_data = 8'h00;
    clr_ovf = 1'b0;

    // Reset held two cycles, then idle with no writes.
    repeat (2) @(negedge clk50m);
    rst = 1'b0;
    checkOutput("t1_status", status, 16'h0004);
    checkOutput("t1_tx", {15'b0, tx}, 16'h0001);
    repeat (20) @(negedge clk50m);
    checkOutput("t1_status_idle", status, 16'h0004);
    checkOutput("t1_tx_idle", {15'b0, tx}, 16'h0001);

    // Single byte 0x55: frame timing relative to the write edge N.
    applyStimulus(1'b1, 8'h55, 1'b0);
    for (int k = 1; k <= 102; k++) begin
      @(negedge clk50m);
      if (k == 1) checkOutput("t2_tx_before_start", {15'b0, tx}, 16'h0001);
      if (k == 2) checkOutput("t2_tx_start", {15'b0, tx}, 16'h0000);
      if (k >= 7 && k <= 97 && ((k - 7) % DIV) == 0) frame[(k - 7) / DIV] = tx;
      if (k == 101) checkOutput("t2_status_stop", status, 16'h0005);
      if (k == 102) checkOutput("t2_status_done", status, 16'h0004);
    end
    checkOutput("t2_start_bit", {15'b0, frame[0]}, 16'h0000);
    checkOutput("t2_data", {8'h00, frame[8:1]}, 16'h0055);
    checkOutput("t2_stop_bit", {15'b0, frame[9]}, 16'h0001);

    // Ten back-to-back writes: nine accepted, the tenth overflows.
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk50m);
      wr_en   = 1'b1;
      wr_data = 8'(i);
    end
    @(negedge clk50m);
    wr_en = 1'b0;
    checkOutput("t3_status_full", status, 16'h0083);
    @(negedge clk50m);
    checkOutput("t3_status_ovf", status, 16'h008B);
    repeat (1000) @(negedge clk50m);
    checkOutput("t3_status_drained", status, 16'h000C);

    // Overflow clear, then clear racing a new overflow.
    applyStimulus(1'b0, 8'h00, 1'b1);
    @(negedge clk50m);
    checkOutput("t4_ovf_cleared", {15'b0, status[3]}, 16'h0000);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk50m);
      wr_en   = 1'b1;
      wr_data = 8'hA0 + 8'(i);
    end
    @(negedge clk50m);
    clr_ovf = 1'b1;
    wr_data = 8'hEE;
    @(negedge clk50m);
    wr_en   = 1'b0;
    clr_ovf = 1'b0;
    @(negedge clk50m);
    checkOutput("t4_ovf_held", {15'b0, status[3]}, 16'h0001);
    checkOutput("t4_count_full", {12'b0, status[7:4]}, 16'h0008);
    repeat (1000) @(negedge clk50m);
    applyStimulus(1'b0, 8'h00, 1'b1);
    @(negedge clk50m);
    checkOutput("t4_status_clean", status, 16'h0004);

    // Reset during the data bits of the first of three queued frames.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk50m);
      wr_en   = 1'b1;
      wr_data = 8'h3C + 8'(i);
    end
    @(negedge clk50m);
    wr_en = 1'b0;
    repeat (27) @(negedge clk50m);
    rst = 1'b1;
    @(negedge clk50m);
    rst = 1'b0;
    checkOutput("t5_tx_reset", {15'b0, tx}, 16'h0001);
    checkOutput("t5_status_reset", status, 16'h0004);
    lows = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk50m);
      if (tx == 1'b0) lows++;
    end
    checkOutput("t5_no_frames", 16'(lows), 16'h0000);

    // Write during the stop bit with an empty queue: one-cycle idle gap.
    applyStimulus(1'b1, 8'hC3, 1'b0);
    for (int k = 1; k <= 110; k++) begin
      @(negedge clk50m);
      if (k == 94) begin
        wr_en   = 1'b1;
        wr_data = 8'h81;
      end
      if (k == 95) wr_en = 1'b0;
      if (k == 97) checkOutput("t6_status_queued", status, 16'h0011);
      if (k == 102) begin
        checkOutput("t6_tx_gap", {15'b0, tx}, 16'h0001);
        checkOutput("t6_status_gap", status, 16'h0010);
      end
      if (k == 103) begin
        checkOutput("t6_tx_start", {15'b0, tx}, 16'h0000);
        checkOutput("t6_status_start", status, 16'h0005);
      end
    end
    repeat (100) @(negedge clk50m);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
